// File: rtl/adc_capture_sequencer_pkg.sv
// Shared definitions for the serial-ADC capture sequencer: FSM encodings,
// default geometry and counter sizing. SCLK is CPOL=0; words arrive MSB-first.
package adc_capture_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CONV  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_QUIET = 3'd4
  } state_t;

  localparam int DEF_DATA_W       = 12;
  localparam int DEF_CLK_DIV      = 2;
  localparam int DEF_CONV_CYCLES  = 4;
  localparam int DEF_QUIET_CYCLES = 2;

  // Wide enough to hold max_val itself, so terminal counts never wrap.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/adc_shift_reg.sv
// Serial-in/parallel-out capture register; shifts MSB-first when ce is high.
module adc_shift_reg
  import adc_capture_sequencer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else if (ce) begin
      q_q <= {q_q[DATA_W-2:0], d};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/adc_capture_sequencer.sv
// Runs one serial-ADC conversion per start request: cs_n, divided SCLK,
// MSB-first capture, one-cycle sample strobe and sticky overrun flag.
module adc_capture_sequencer
  import adc_capture_sequencer_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int CONV_CYCLES  = DEF_CONV_CYCLES,
  parameter int QUIET_CYCLES = DEF_QUIET_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              overrun_clr,
  input  logic              adc_sdata,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic              busy,
  output logic              sample_valid,
  output logic [DATA_W-1:0] sample_data,
  output logic              overrun,
  output logic [2:0]        dbg_state_o
);

  localparam int WAIT_W  = cnt_w(CONV_CYCLES);
  localparam int DIV_W   = cnt_w(CLK_DIV);
  localparam int BIT_W   = cnt_w(DATA_W);
  localparam int QUIET_W = cnt_w(QUIET_CYCLES);

  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(CONV_CYCLES - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(DATA_W);
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYCLES - 1);

  state_t               state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [QUIET_W-1:0]   quiet_q, quiet_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sclk_q, sclk_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 start_prev_q;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [DATA_W-1:0]    shift_q;
  logic                 div_tick;
  logic                 sclk_rise;

  assign div_tick  = (state_q == ST_SHIFT) && (div_q == DIV_LAST);
  assign sclk_rise = div_tick && !sclk_q;

  adc_shift_reg #(.DATA_W(DATA_W)) u_shift (
    .clk   (clk),
    .reset (reset),
    .ce    (sclk_rise),
    .d     (adc_sdata),
    .q     (shift_q)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    div_d   = div_q;
    bit_d   = bit_q;
    quiet_d = quiet_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    data_d  = data_q;
    ovr_d   = ovr_q;

    // A held start is a back-to-back request, not an overrun; only a new
    // request (rising edge) arriving outside IDLE counts as lost. Set beats clear.
    if (overrun_clr) ovr_d = 1'b0;
    if (start && !start_prev_q && (state_q != ST_IDLE)) ovr_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CONV;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          wait_d  = '0;
        end
      end
      ST_CONV: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (div_tick) begin
          div_d  = '0;
          sclk_d = !sclk_q;
          if (!sclk_q) begin
            bit_d = bit_q + BIT_W'(1);
          end else if (bit_q == BIT_LAST) begin
            state_d = ST_DONE;
            cs_n_d  = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_QUIET;
        valid_d = 1'b1;
        data_d  = shift_q;
        quiet_d = '0;
      end
      ST_QUIET: begin
        if (quiet_q == QUIET_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          quiet_d = quiet_q + QUIET_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      div_q        <= '0;
      bit_q        <= '0;
      quiet_q      <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      ovr_q        <= 1'b0;
      start_prev_q <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      quiet_q      <= quiet_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      ovr_q        <= ovr_d;
      start_prev_q <= start;
      data_q       <= data_d;
    end
  end

  // sample_valid has no ready: the consumer must take sample_data in the
  // single cycle the strobe is high; sample_data then holds until the next strobe.
  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign busy         = busy_q;
  assign sample_valid = valid_q;
  assign sample_data  = data_q;
  assign overrun      = ovr_q;
  assign dbg_state_o  = state_q;

endmodule
